motor_cmd_shaper: RTL and testbench



---
 rtl/motor_cmd_shaper.sv | 123 ++++++++++++
 tb/tb_motor_cmd_shaper.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_shaper.sv
// Per-channel slew limiter for sign-magnitude motor commands, with brake-to-zero
// and a dead-time hold before any direction reversal.
module motor_cmd_shaper #(
   parameter int unsigned CH   = 4,
   parameter int unsigned W    = 8,
   parameter int unsigned STEP = 4,
   parameter int unsigned DEAD = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic                cmd_load,
   input  logic [CH*W-1:0]     cmd,
   output logic [CH*(W-1)-1:0] mag_out,
   output logic [CH-1:0]       dir_out,
   output logic [CH-1:0]       busy
);

   localparam int unsigned M  = W - 1;
   localparam int unsigned CW = (DEAD > 1) ? $clog2(DEAD) : 1;
   localparam logic [W-1:0]  StepW    = W'(STEP);
   localparam logic [CW-1:0] DeadLoad = CW'(DEAD - 1);

   typedef enum logic [1:0] {StTrack, StBrake, StDead} state_e;

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_e        st_q, st_d;
      logic [M-1:0]  mag_q, mag_d, tgt_mag_q, tgt_mag_d;
      logic          dir_q, dir_d, tgt_dir_q, tgt_dir_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [W-1:0]  cmd_ch, mag_w, tgt_w, up_sum, dn_dif;
      logic [M-1:0]  up_mag, dn_mag, brk_mag, brk_next;

      assign cmd_ch = cmd[i*W +: W];
      assign mag_w  = {1'b0, mag_q};
      assign tgt_w  = {1'b0, tgt_mag_q};
      // One extra bit of headroom so neither sum can wrap before clamping.
      assign up_sum   = mag_w + StepW;
      assign dn_dif   = mag_w - StepW;
      assign up_mag   = (up_sum >= tgt_w) ? tgt_mag_q : up_sum[M-1:0];
      assign dn_mag   = ((mag_w < StepW) || (dn_dif <= tgt_w)) ? tgt_mag_q : dn_dif[M-1:0];
      assign brk_mag  = (mag_w < StepW) ? '0 : dn_dif[M-1:0];
      assign brk_next = tick ? brk_mag : mag_q;

      always_comb begin
         tgt_mag_d = tgt_mag_q;
         tgt_dir_d = tgt_dir_q;
         if (cmd_load) begin
            tgt_mag_d = cmd_ch[M-1:0];
            // A zero-magnitude command (including "-0") never requests a reversal.
            tgt_dir_d = (cmd_ch[M-1:0] == '0) ? dir_q : cmd_ch[W-1];
         end
      end

      always_comb begin
         st_d  = st_q;
         mag_d = mag_q;
         dir_d = dir_q;
         cnt_d = cnt_q;
         case (st_q)
            StTrack: begin
               if (tgt_dir_q != dir_q) begin
                  if (mag_q != '0) begin
                     st_d = StBrake;
                  end else begin
                     st_d  = StDead;
                     cnt_d = DeadLoad;
                  end
               end else if (tick) begin
                  if (mag_q < tgt_mag_q)      mag_d = up_mag;
                  else if (mag_q > tgt_mag_q) mag_d = dn_mag;
               end
            end
            StBrake: begin
               if (tgt_dir_q == dir_q) begin
                  st_d = StTrack;
               end else begin
                  mag_d = brk_next;
                  if (brk_next == '0) begin
                     st_d  = StDead;
                     cnt_d = DeadLoad;
                  end
               end
            end
            StDead: begin
               mag_d = '0;
               if (tgt_dir_q == dir_q) begin
                  st_d = StTrack;
               end else if (cnt_q == '0) begin
                  dir_d = tgt_dir_q;
                  st_d  = StTrack;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: st_d = StTrack;
         endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q      <= StTrack;
            mag_q     <= '0;
            dir_q     <= 1'b0;
            tgt_mag_q <= '0;
            tgt_dir_q <= 1'b0;
            cnt_q     <= '0;
         end else begin
            st_q      <= st_d;
            mag_q     <= mag_d;
            dir_q     <= dir_d;
            tgt_mag_q <= tgt_mag_d;
            tgt_dir_q <= tgt_dir_d;
            cnt_q     <= cnt_d;
         end
      end

      assign mag_out[i*M +: M] = mag_q;
      assign dir_out[i]        = dir_q;
      assign busy[i]           = (st_q != StTrack) | (mag_q != tgt_mag_q) | (dir_q != tgt_dir_q);
   end

endmodule

// File: tb/tb_motor_cmd_shaper.sv
// Scoreboard bench for motor_cmd_shaper: per-cycle expected mag/dir/busy entries are
// queued as stimulus is driven and compared after each clock edge.
module tb_motor_cmd_shaper;

   localparam int CH = 4;
   localparam int W  = 8;
   localparam int M  = W - 1;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               tick = 1'b0;
   logic               cmd_load = 1'b0;
   logic [CH*W-1:0]    cmd = '0;
   logic [CH*M-1:0]    mag_out;
   logic [CH-1:0]      dir_out;
   logic [CH-1:0]      busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int           ch;
      logic [M-1:0] mag;
      logic         dir;
      logic         busy;
   } exp_t;

   exp_t sbq[$];
   exp_t rev_q[$];

   motor_cmd_shaper #(.CH(CH), .W(W), .STEP(4), .DEAD(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .cmd_load (cmd_load),
      .cmd      (cmd),
      .mag_out  (mag_out),
      .dir_out  (dir_out),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(input int ch, input logic [W-1:0] v);
      cmd[ch*W +: W] = v;
   endtask

   function automatic logic [M-1:0] mag_of(input int ch);
      return mag_out[ch*M +: M];
   endfunction

   task automatic do_reset();
      tick = 1'b0;
      cmd_load = 1'b0;
      cmd = '0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      cycle();
   endtask

   // Hand-derived reversal from dir 0 / mag m0 to command 0x85, STEP 4, DEAD 16, tick always on.
   task automatic build_rev(input int ch, input int m0);
      int m;
      rev_q.delete();
      rev_q.push_back('{ch, M'(m0), 1'b0, 1'b1});
      rev_q.push_back('{ch, M'(m0), 1'b0, 1'b1});
      m = m0;
      while (m > 0) begin
         m = (m > 4) ? m - 4 : 0;
         rev_q.push_back('{ch, M'(m), 1'b0, 1'b1});
      end
      repeat (15) rev_q.push_back('{ch, 7'd0, 1'b0, 1'b1});
      rev_q.push_back('{ch, 7'd0, 1'b1, 1'b1});
      rev_q.push_back('{ch, 7'd4, 1'b1, 1'b1});
      rev_q.push_back('{ch, 7'd5, 1'b1, 1'b0});
   endtask

   task automatic test_reset();
      checks++;
      if (mag_out !== '0 || dir_out !== '0 || busy !== '0) begin
         errors++;
         $display("FAIL reset_initial: got mag=%h dir=%b busy=%b, want all 0", mag_out, dir_out, busy);
      end
      rst_n = 1'b1;
      set_cmd(0, 8'h64);
      cmd_load = 1'b1;
      cycle();
      cmd_load = 1'b0;
      tick = 1'b1;
      repeat (3) cycle();
      checks++;
      if (mag_of(0) !== 7'd12) begin
         errors++;
         $display("FAIL reset_preramp: got mag=%0d, want 12", mag_of(0));
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (mag_out !== '0 || dir_out !== '0 || busy !== '0) begin
         errors++;
         $display("FAIL reset_async: got mag=%h dir=%b busy=%b, want all 0", mag_out, dir_out, busy);
      end
      #1 rst_n = 1'b1;
      repeat (4) cycle();
      checks++;
      if (mag_out !== '0 || dir_out !== '0 || busy !== '0) begin
         errors++;
         $display("FAIL reset_hold: got mag=%h dir=%b busy=%b, want all 0", mag_out, dir_out, busy);
      end
      tick = 1'b0;
      cmd = '0;
   endtask

   task automatic test_ramp_up();
      exp_t e;
      set_cmd(0, 8'h64);
      cmd_load = 1'b1;
      tick = 1'b0;
      sbq.push_back('{0, 7'd0, 1'b0, 1'b1});
      for (int k = 0; k <= 25; k++) begin
         if (k > 0) begin
            sbq.push_back('{0, M'(4 * k), 1'b0, (k < 25)});
            for (int c = 1; c < CH; c++) sbq.push_back('{c, 7'd0, 1'b0, 1'b0});
         end
         cycle();
         cmd_load = 1'b0;
         tick = 1'b1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (mag_of(e.ch) !== e.mag || dir_out[e.ch] !== e.dir || busy[e.ch] !== e.busy) begin
               errors++;
               $display("FAIL ramp_up ch%0d step%0d: got mag=%0d dir=%b busy=%b, want mag=%0d dir=%b busy=%b",
                        e.ch, k, mag_of(e.ch), dir_out[e.ch], busy[e.ch], e.mag, e.dir, e.busy);
            end
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_ramp_down();
      exp_t e;
      set_cmd(0, 8'h02);
      cmd_load = 1'b1;
      tick = 1'b0;
      sbq.push_back('{0, 7'd100, 1'b0, 1'b1});
      for (int k = 0; k <= 25; k++) begin
         if (k > 0 && k < 25) sbq.push_back('{0, M'(100 - 4 * k), 1'b0, 1'b1});
         if (k == 25) sbq.push_back('{0, 7'd2, 1'b0, 1'b0});
         cycle();
         cmd_load = 1'b0;
         tick = 1'b1;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (mag_of(e.ch) !== e.mag || dir_out[e.ch] !== e.dir || busy[e.ch] !== e.busy) begin
               errors++;
               $display("FAIL ramp_down step%0d: got mag=%0d dir=%b busy=%b, want mag=%0d dir=%b busy=%b",
                        k, mag_of(e.ch), dir_out[e.ch], busy[e.ch], e.mag, e.dir, e.busy);
            end
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_reversal();
      exp_t e;
      // Bring ch0 from 2 up to 20: 6,10,14,18,20 (last step clamps).
      set_cmd(0, 8'h14);
      cmd_load = 1'b1;
      cycle();
      cmd_load = 1'b0;
      tick = 1'b1;
      repeat (5) cycle();
      checks++;
      if (mag_of(0) !== 7'd20 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL reversal_setup: got mag=%0d busy=%b, want mag=20 busy=0", mag_of(0), busy[0]);
      end
      set_cmd(0, 8'h85);
      cmd_load = 1'b1;
      build_rev(0, 20);
      for (int c = 0; c < rev_q.size(); c++) begin
         sbq.push_back(rev_q[c]);
         cycle();
         cmd_load = 1'b0;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (mag_of(e.ch) !== e.mag || dir_out[e.ch] !== e.dir || busy[e.ch] !== e.busy) begin
               errors++;
               $display("FAIL reversal cyc%0d: got mag=%0d dir=%b busy=%b, want mag=%0d dir=%b busy=%b",
                        c, mag_of(e.ch), dir_out[e.ch], busy[e.ch], e.mag, e.dir, e.busy);
            end
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_abort_dead();
      exp_t e;
      do_reset();
      set_cmd(0, 8'h14);
      cmd_load = 1'b1;
      cycle();
      cmd_load = 1'b0;
      tick = 1'b1;
      repeat (5) cycle();
      checks++;
      if (mag_of(0) !== 7'd20) begin
         errors++;
         $display("FAIL abort_setup: got mag=%0d, want 20", mag_of(0));
      end
      set_cmd(0, 8'h85);
      cmd_load = 1'b1;
      for (int c = 0; c < 15; c++) begin
         case (c)
            0, 1:    sbq.push_back('{0, 7'd20, 1'b0, 1'b1});
            2:       sbq.push_back('{0, 7'd16, 1'b0, 1'b1});
            3:       sbq.push_back('{0, 7'd12, 1'b0, 1'b1});
            4:       sbq.push_back('{0, 7'd8, 1'b0, 1'b1});
            5:       sbq.push_back('{0, 7'd4, 1'b0, 1'b1});
            13:      sbq.push_back('{0, 7'd4, 1'b0, 1'b1});
            14:      sbq.push_back('{0, 7'd5, 1'b0, 1'b0});
            default: sbq.push_back('{0, 7'd0, 1'b0, 1'b1});
         endcase
         // Dead-time cycle 5: retarget back to forward direction.
         if (c == 11) begin
            set_cmd(0, 8'h05);
            cmd_load = 1'b1;
         end
         cycle();
         cmd_load = 1'b0;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (mag_of(e.ch) !== e.mag || dir_out[e.ch] !== e.dir || busy[e.ch] !== e.busy) begin
               errors++;
               $display("FAIL abort_dead cyc%0d: got mag=%0d dir=%b busy=%b, want mag=%0d dir=%b busy=%b",
                        c, mag_of(e.ch), dir_out[e.ch], busy[e.ch], e.mag, e.dir, e.busy);
            end
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_zero_indep();
      exp_t e;
      do_reset();
      set_cmd(0, 8'h0C);
      set_cmd(2, 8'h14);
      cmd_load = 1'b1;
      cycle();
      cmd_load = 1'b0;
      tick = 1'b1;
      repeat (5) cycle();
      checks++;
      if (mag_of(0) !== 7'd12 || mag_of(2) !== 7'd20) begin
         errors++;
         $display("FAIL indep_setup: got ch0=%0d ch2=%0d, want ch0=12 ch2=20", mag_of(0), mag_of(2));
      end
      set_cmd(0, 8'h80);
      set_cmd(2, 8'h85);
      cmd_load = 1'b1;
      build_rev(2, 20);
      for (int c = 0; c < rev_q.size(); c++) begin
         sbq.push_back(rev_q[c]);
         case (c)
            0:       sbq.push_back('{0, 7'd12, 1'b0, 1'b1});
            1:       sbq.push_back('{0, 7'd8, 1'b0, 1'b1});
            2:       sbq.push_back('{0, 7'd4, 1'b0, 1'b1});
            default: sbq.push_back('{0, 7'd0, 1'b0, 1'b0});
         endcase
         sbq.push_back('{1, 7'd0, 1'b0, 1'b0});
         cycle();
         cmd_load = 1'b0;
         while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks++;
            if (mag_of(e.ch) !== e.mag || dir_out[e.ch] !== e.dir || busy[e.ch] !== e.busy) begin
               errors++;
               $display("FAIL zero_indep ch%0d cyc%0d: got mag=%0d dir=%b busy=%b, want mag=%0d dir=%b busy=%b",
                        e.ch, c, mag_of(e.ch), dir_out[e.ch], busy[e.ch], e.mag, e.dir, e.busy);
            end
         end
      end
      tick = 1'b0;
   endtask

   initial begin
      #2;
      test_reset();
      test_ramp_up();
      test_ramp_down();
      test_reversal();
      test_abort_dead();
      test_zero_indep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
